// File: rtl/signed_add_pipe.sv
// Two-stage pipelined signed add/sub with overflow flag, optional clamp
// and a feedback accumulator that is usable on back-to-back beats.
module signed_add_pipe #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_acc,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_ovf,
  output logic             ovf_sticky,
  input  logic             ovf_clr
);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             acc;
  } s1_t;

  localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  s1_t              s1_q;
  logic             s1_valid;
  logic             s1_load;
  logic             s2_load;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] opb;
  logic [WIDTH:0]   ea;
  logic [WIDTH:0]   eb;
  logic [WIDTH:0]   full;
  logic             ovf;
  logic [WIDTH-1:0] res;

  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = !s1_valid || !out_valid || out_ready;

  // Accumulator is read at S2 load, so a result written on one edge
  // is already the operand of the beat loading on the next edge.
  assign opb  = s1_q.acc ? acc : s1_q.b;
  assign ea   = {s1_q.a[WIDTH-1], s1_q.a};
  assign eb   = {opb[WIDTH-1], opb};
  assign full = s1_q.sub ? (ea - eb) : (ea + eb);
  assign ovf  = full[WIDTH] ^ full[WIDTH-1];

  always_comb begin
    res = full[WIDTH-1:0];
    unique case (1'b1)
      (SATURATE && ovf && full[WIDTH]):  res = MINV;
      (SATURATE && ovf && !full[WIDTH]): res = MAXV;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (s1_load && in_valid) begin
      s1_q <= '{a: in_a, b: in_b, sub: in_sub, acc: in_acc};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_s     <= '0;
      out_ovf   <= 1'b0;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      out_s     <= res;
      out_ovf   <= ovf;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (acc_clr) begin
      acc <= '0;
    end else if (s2_load && s1_q.acc) begin
      acc <= res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
    end else if (s2_load && ovf) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end
  end

endmodule
